throw_power_meter: RTL and testbench
====================================

Name: throw_power_meter

Overview:
- Consumes the local turn controller's `enable_draw` / `throw_enable` handshake during an active dog turn.
- While the throw key is held, drives a ramping power bar, either ping-pong or saturating depending on build.
- On release, freezes the bar value; when the throw is enabled, issues a one-cycle launch pulse carrying that value.
- Feeds the projectile physics stage and the power-bar draw logic.

Parameters:
- CLK_HZ, 65000000, system clock frequency in Hz.
- STEP_HZ, 50, meter step rate in Hz. TICK_DIV = CLK_HZ/STEP_HZ; must be ≥ 2.
- PWR_W, 7, power word width.
- PWR_MAX, 100, maximum power value; must be ≥ 1 and < 2**PWR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- turn_active  in  1  high while the local player owns the turn (`dog_turn`)
- enable_draw  in  1  high while the throw key is held (charging)
- throw_enable  in  1  high once the key is released and the throw window is open
- power  out  PWR_W  live meter value for the power-bar draw
- meter_dir  out  1  ramp direction: 1 = up, 0 = down
- power_valid  out  1  frozen value held in launch_power
- launch  out  1  one-cycle launch strobe
- launch_power  out  PWR_W  frozen power; stable while power_valid=1

Behaviour:
- All outputs are registered.
- Reset values: power=0, meter_dir=1, power_valid=0, launch=0, launch_power=0, state=IDLE, prescaler=0, en_q=0.
- en_q is enable_draw registered one cycle; used for edge detection.
- Abort: turn_active=0 in any cycle has priority over all other events. Next cycle: state=IDLE and every output at its reset value. Any pending launch is dropped.
- States:
  - IDLE: power=0, meter_dir=1, launch=0.
    - enable_draw=1 && en_q=0 → CHARGE; prescaler cleared.
    - enable_draw already high on entry without a rising edge: stay IDLE.
  - CHARGE: prescaler counts 0..TICK_DIV-1; tick asserts when prescaler==TICK_DIV-1, then prescaler wraps to 0.
    - On tick, power steps by ±1 per meter_dir (ramp rules below).
    - enable_draw=0: launch_power<=power (value before any same-cycle tick), power_valid<=1 → HOLD. This happens regardless of throw_enable in that cycle; upstream lowers enable_draw and raises throw_enable in the same cycle.
    - throw_enable=1 while enable_draw=1: ignored.
  - HOLD: power frozen, prescaler idle.
    - throw_enable=1 (level, not edge) → launch=1 for exactly one cycle → LAUNCHED.
    - Launch latency is 1 cycle after HOLD entry when throw_enable is already high.
  - LAUNCHED: launch=0; power_valid and launch_power held.
    - throw_enable=0 → IDLE; power_valid<=0 and power<=0 on that transition.
    - enable_draw rising here is ignored until IDLE is reached.
- Ramp rules:
  - power never exceeds PWR_MAX and never underflows below 0.
  - With power 0 at a tick and meter_dir=0: meter_dir<=1 and power stays 0. The turning tick produces no value change.
- Arithmetic: unsigned, PWR_W bits. Prescaler width is $clog2(TICK_DIV).
- launch is never asserted in two consecutive cycles. Only one launch occurs per charge.

Optional Feature:
- Macro: POWER_METER_PINGPONG_EN.
- Defined: at a tick with power==PWR_MAX and meter_dir=1, meter_dir<=0 and power stays PWR_MAX. Subsequent ticks decrement down to 0, then the bar turns upward again as per the ramp rules.
- Undefined: meter_dir is constant 1 and power saturates at PWR_MAX. The PWR_MAX turn-around logic is not synthesised.

Test Plan:
Use CLK_HZ=100, STEP_HZ=10 (TICK_DIV=10), PWR_MAX=5.
- Reset: rst=1 for 3 cycles with random inputs → power=0, meter_dir=1, power_valid=0, launch=0, launch_power=0.
- Basic throw: turn_active=1; enable_draw high for 35 cycles; then enable_draw=0 and throw_enable=1 in the same cycle → launch_power=3, power_valid=1. launch is high exactly one cycle, one cycle after HOLD entry, and never asserts again.
- Ping-pong (macro defined): hold enable_draw 90 cycles → power sequence 0,1,2,3,4,5,5,4,3,2 with meter_dir falling at the 6th tick → launch_power=2 on release. Macro undefined: same stimulus → power sticks at 5 and launch_power=5.
- Abort: turn_active falls while in CHARGE at power=2, and again while in HOLD → next cycle all outputs are at reset values and launch is never asserted.
- Release/tick collision: enable_draw falls on the exact tick cycle with power=1 → launch_power=1, not 2.
- Re-arm: throw_enable held high after launch → no second launch. throw_enable=0 → IDLE with power_valid=0. A new enable_draw rising edge restarts the ramp at 0.

Source files
------------

// File: rtl/throw_power_meter.sv
// throw_power_meter: power-bar meter for the local dog's throw.
// The bar ramps while the throw key is held, freezes on release, and a
// one-cycle launch strobe carries the frozen value once the throw window
// opens. A drop of turn_active aborts everything back to idle.
//
// Build option: define POWER_METER_PINGPONG_EN to make the bar bounce
// between 0 and PWR_MAX. Without it the bar only climbs and saturates at
// PWR_MAX.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no charge in progress, bar at 0, waiting for key press edge
// CHARGE   | key held, bar steps once per prescaler tick
// HOLD     | key released, value frozen, waiting for throw_enable
// LAUNCHED | strobe issued, waiting for throw_enable to drop
module throw_power_meter #(
   parameter int CLK_HZ  = 65000000,
   parameter int STEP_HZ = 50,
   parameter int PWR_W   = 7,
   parameter int PWR_MAX = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             turn_active,
   input  logic             enable_draw,
   input  logic             throw_enable,
   output logic [PWR_W-1:0] power,
   output logic             meter_dir,
   output logic             power_valid,
   output logic             launch,
   output logic [PWR_W-1:0] launch_power
);

   localparam int TICK_DIV = CLK_HZ / STEP_HZ;
   localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
   localparam logic [PWR_W-1:0] P_MAX   = PWR_W'(PWR_MAX);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHARGE   = 2'd1,
      HOLD     = 2'd2,
      LAUNCHED = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [PS_W-1:0]  ps, ps_nx;
   logic             en_q;
   logic [PWR_W-1:0] power_nx, lp_nx;
   logic             dir_nx, valid_nx, launch_nx;
   logic             tick;

   assign tick = (ps == PS_LAST);

   // State, prescaler, output and key-edge registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ps           <= '0;
         en_q         <= 1'b0;
         power        <= '0;
         meter_dir    <= 1'b1;
         power_valid  <= 1'b0;
         launch       <= 1'b0;
         launch_power <= '0;
      end else begin
         state        <= state_nx;
         ps           <= ps_nx;
         en_q         <= enable_draw;
         power        <= power_nx;
         meter_dir    <= dir_nx;
         power_valid  <= valid_nx;
         launch       <= launch_nx;
         launch_power <= lp_nx;
      end
   end

   // Next-state, ramp and output computation; abort overrides everything.
   always_comb begin
      state_nx  = state;
      ps_nx     = ps;
      power_nx  = power;
      dir_nx    = meter_dir;
      valid_nx  = power_valid;
      launch_nx = 1'b0;
      lp_nx     = launch_power;

      if (!turn_active) begin
         state_nx = IDLE;
         ps_nx    = '0;
         power_nx = '0;
         dir_nx   = 1'b1;
         valid_nx = 1'b0;
         lp_nx    = '0;
      end else begin
         case (state)
            IDLE: begin
               power_nx = '0;
               dir_nx   = 1'b1;
               if (enable_draw && !en_q) begin
                  state_nx = CHARGE;
                  ps_nx    = '0;
               end
            end
            CHARGE: begin
               if (!enable_draw) begin
                  // Freeze the pre-tick value; a tick landing on the release
                  // cycle is discarded.
                  lp_nx    = power;
                  valid_nx = 1'b1;
                  state_nx = HOLD;
               end else if (tick) begin
                  ps_nx = '0;
                  if (meter_dir) begin
                     if (power < P_MAX) begin
                        power_nx = power + 1'b1;
                     end else begin
`ifdef POWER_METER_PINGPONG_EN
                        dir_nx = 1'b0;
`else
                        dir_nx = 1'b1;
`endif
                     end
                  end else if (power == '0) begin
                     // Turning tick: direction flips, value stays at 0.
                     dir_nx = 1'b1;
                  end else begin
                     power_nx = power - 1'b1;
                  end
               end else begin
                  ps_nx = ps + 1'b1;
               end
            end
            HOLD: begin
               if (throw_enable) begin
                  launch_nx = 1'b1;
                  state_nx  = LAUNCHED;
               end
            end
            LAUNCHED: begin
               if (!throw_enable) begin
                  state_nx = IDLE;
                  valid_nx = 1'b0;
                  power_nx = '0;
                  dir_nx   = 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_throw_power_meter.sv
// Bench for throw_power_meter with CLK_HZ=100, STEP_HZ=10 (10-cycle tick),
// PWR_MAX=5. Expected launch values are queued at release and matched when
// the launch strobe appears. Build with POWER_METER_PINGPONG_EN to check
// the bouncing ramp.
module tb_throw_power_meter;

   localparam int PWR_W = 7;

   logic             clk;
   logic             rst;
   logic             turn_active;
   logic             enable_draw;
   logic             throw_enable;
   logic [PWR_W-1:0] power;
   logic             meter_dir;
   logic             power_valid;
   logic             launch;
   logic [PWR_W-1:0] launch_power;

   int n_chk = 0;
   int n_err = 0;
   int sb_q[$];
   logic launch_prev = 1'b0;

   throw_power_meter #(
      .CLK_HZ (100),
      .STEP_HZ(10),
      .PWR_W  (PWR_W),
      .PWR_MAX(5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .turn_active (turn_active),
      .enable_draw (enable_draw),
      .throw_enable(throw_enable),
      .power       (power),
      .meter_dir   (meter_dir),
      .power_valid (power_valid),
      .launch      (launch),
      .launch_power(launch_power)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_power"}, 32'(power), 0);
      chk({tag, "_dir"}, 32'(meter_dir), 1);
      chk({tag, "_valid"}, 32'(power_valid), 0);
      chk({tag, "_launch"}, 32'(launch), 0);
      chk({tag, "_lpower"}, 32'(launch_power), 0);
   endtask

   // Scoreboard: every launch strobe must match a queued release value and
   // must never repeat on the following cycle.
   always @(negedge clk) begin
      if (!rst && launch) begin
         chk("launch_consec", 32'(launch_prev), 0);
         if (sb_q.size() == 0) chk("launch_unexp", 32'(launch), 0);
         else chk("launch_value", 32'(launch_power), 32'(sb_q.pop_front()));
      end
      launch_prev = launch;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_pow[9];
      int exp_dir[9];
`ifdef POWER_METER_PINGPONG_EN
      exp_pow = '{1, 2, 3, 4, 5, 5, 4, 3, 2};
      exp_dir = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
`else
      exp_pow = '{1, 2, 3, 4, 5, 5, 5, 5, 5};
      exp_dir = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif

      // Reset with random inputs.
      rst          = 1'b1;
      turn_active  = 1'($urandom);
      enable_draw  = 1'($urandom);
      throw_enable = 1'($urandom);
      repeat (3) step();
      chk_reset_outputs("reset");
      rst          = 1'b0;
      turn_active  = 1'b1;
      enable_draw  = 1'b0;
      throw_enable = 1'b0;
      step();
      step();

      // Basic throw: 35 cycles of key-hold, release and throw_enable together.
      enable_draw = 1'b1;
      step();
      repeat (34) step();
      chk("basic_power", 32'(power), 3);
      enable_draw  = 1'b0;
      throw_enable = 1'b1;
      sb_q.push_back(3);
      step();
      chk("basic_hold_valid", 32'(power_valid), 1);
      chk("basic_hold_lpower", 32'(launch_power), 3);
      chk("basic_hold_launch", 32'(launch), 0);
      step();
      chk("basic_launch", 32'(launch), 1);
      step();
      chk("basic_launch_off", 32'(launch), 0);
      chk("basic_valid_held", 32'(power_valid), 1);

      // Re-arm: throw_enable kept high yields no second launch.
      repeat (5) step();
      chk("rearm_no_launch", 32'(launch), 0);
      throw_enable = 1'b0;
      step();
      chk("rearm_valid", 32'(power_valid), 0);
      chk("rearm_power", 32'(power), 0);

      // New charge restarts at 0; release lands on the second tick.
      enable_draw = 1'b1;
      step();
      repeat (9) step();
      chk("restart_pre_tick", 32'(power), 0);
      step();
      chk("restart_first_tick", 32'(power), 1);
      repeat (9) step();
      enable_draw = 1'b0;
      sb_q.push_back(1);
      step();
      chk("collide_lpower", 32'(launch_power), 1);
      chk("collide_valid", 32'(power_valid), 1);
      throw_enable = 1'b1;
      step();
      chk("collide_launch", 32'(launch), 1);
      throw_enable = 1'b0;
      step();
      chk("collide_idle_valid", 32'(power_valid), 0);

      // Long hold: nine ticks, ping-pong or saturating by build.
      enable_draw = 1'b1;
      step();
      for (int t = 0; t < 9; t++) begin
         repeat (10) step();
         chk($sformatf("ramp_pow%0d", t), 32'(power), 32'(exp_pow[t]));
         chk($sformatf("ramp_dir%0d", t), 32'(meter_dir), 32'(exp_dir[t]));
      end
      repeat (4) step();
      enable_draw = 1'b0;
      sb_q.push_back(exp_pow[8]);
      step();
      chk("ramp_lpower", 32'(launch_power), 32'(exp_pow[8]));
      throw_enable = 1'b1;
      step();
      chk("ramp_launch", 32'(launch), 1);
      throw_enable = 1'b0;
      step();

      // Abort during CHARGE at power 2.
      enable_draw = 1'b1;
      step();
      repeat (24) step();
      chk("abort_c_power", 32'(power), 2);
      turn_active = 1'b0;
      step();
      chk_reset_outputs("abort_c");
      turn_active = 1'b1;
      enable_draw = 1'b0;
      step();
      step();

      // Abort during HOLD, with throw_enable rising in the same cycle.
      enable_draw = 1'b1;
      step();
      repeat (14) step();
      enable_draw = 1'b0;
      step();
      chk("abort_h_valid", 32'(power_valid), 1);
      chk("abort_h_lpower", 32'(launch_power), 1);
      step();
      turn_active  = 1'b0;
      throw_enable = 1'b1;
      step();
      chk_reset_outputs("abort_h");
      step();
      chk("abort_h_no_launch", 32'(launch), 0);
      turn_active  = 1'b1;
      throw_enable = 1'b0;
      repeat (3) step();
      chk("abort_h_after_valid", 32'(power_valid), 0);

      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
